debug_data_sender: RTL and testbench
====================================

// Module: debug_data_sender
// PURPOSE
//  Debug serializer: captures a 40-bit word in the fast in_clk domain and shifts it out
//  on sout, one bit per rising edge of the slow out_clk input (about 110x slower).
//  out_clk is a sampled strobe, not a clock.
//  Used to stream internal ASIC state to a logic analyser or probe pin.
//  State-visibility outputs expose the FSM for scope triggering.
// PARAMETERS
//  DATA_WIDTH   40  bits per frame (payload, excluding start/stop)
//  SYNC_STAGES  2   flip-flops synchronising out_clk and in_latch into in_clk
// PORTS
//  in_clk       in   1           sole clock; all logic is rising-edge in_clk
//  rst          in   1           synchronous, active-high reset
//  in_latch     in   1           capture request; rising edge captures data
//  data         in   DATA_WIDTH  word to send; sampled on the in_latch capture cycle
//  state        out  1           busy: frame in progress OR word pending
//  int_state_1  out  1           FSM encoding bit 0
//  int_state_2  out  1           FSM encoding bit 1
//  out_clk      in   1           bit-rate strobe; asynchronous, synchronised internally
//  sout         out  1           serial output; idle level 1
// BEHAVIOUR
//  - Sync: out_clk through SYNC_STAGES FFs plus one delay FF.
//  - tick = one-cycle pulse on each synchronised 0->1 transition of out_clk.
//  - Capture: in_latch is registered; a capture occurs when latch=1 and its previous value was 0.
//  - Holding an in_latch level captures once only.
//  - On capture: hold_reg <= data and pending <= 1, in any FSM state.
//  - A second capture before the word is consumed overwrites hold_reg (last wins).
//  - FSM (2-bit): IDLE=0, START=1, DATA=2, STOP=3. int_state_2:int_state_1 = FSM code.
//  - IDLE: sout=1. On tick with pending: shreg<=hold_reg, pending<=0, sout<=0, go START.
//  - START: on tick: sout<=shreg[MSB], bitcnt<=1, go DATA.
//  - DATA: on tick:
//      - if bitcnt<DATA_WIDTH: shift left, sout<=next bit, bitcnt++;
//      - else sout<=1, go STOP.
//    Payload is sent MSB first, one bit per out_clk period.
//  - STOP: on tick:
//      - if pending, behave as IDLE-with-pending: start bit immediately, no idle gap;
//      - else go IDLE.
//  - Frame = start(0) + 40 data bits + stop(1) = 42 out_clk periods.
//  - Each bit is held for exactly one out_clk period.
//  - Capture and consume in the same cycle: the consume uses the old hold_reg.
//    The new capture sets pending again and is sent in the next frame.
//  - Capture on the same cycle as a tick in IDLE: not sent on that tick; the word starts on the following tick.
//  - Latency: sout/FSM update on the in_clk edge where tick=1, which is
//    SYNC_STAGES+1 in_clk cycles after out_clk rises.
//  - state = (FSM != IDLE) | pending; registered-equivalent, no glitches.
//  - bitcnt: 6 bits, saturates and never wraps.
//  - sout, state and int_state_* are all registered.
//  - Reset: FSM=IDLE, sout=1, pending=0, state=0, int_state_*=0.
//    Also clears shreg, hold_reg, bitcnt and sync FFs, so no spurious tick occurs after reset.
//  - Reset mid-frame aborts the frame; sout=1 on the next edge and the pending word is discarded.
// TESTING
//  - Reset: rst=1 for 2 cycles -> sout=1, state=0, int_state_2/1=00, with no ticks needed.
//  - Single frame:
//      - stimulus: capture 40'hA999999991 while idle;
//      - state=1 immediately; at successive ticks sout = 0, 1,0,1,0,1,0,0,1,1,0,...,0,0,0,1, then 1;
//      - FSM returns to 00 and state=0 after 42 ticks.
//  - Queued frame:
//      - stimulus: capture 40'hA999999981 10 ticks into the frame above;
//      - the first frame completes unchanged;
//      - at the tick after the stop bit sout=0 (new start), then 40'hA999999981 MSB first, with no idle period.
//  - Overwrite: two captures (40'hE999999993, then 40'h0000000001) before the start tick -> only the second word is sent.
//  - Level latch: in_latch held high for 50 cycles -> exactly one frame sent; pending clears after START.
//  - Mid-frame reset: rst during the DATA state -> sout=1 and FSM=IDLE on the next edge.
//    No frame follows unless a new capture occurs.

Source files
------------

// File: rtl/debug_data_sender.sv
// rtl/debug_data_sender.sv - captures a word on in_clk and serialises it on sout at the out_clk rate
module debug_data_sender #(
  parameter int DATA_WIDTH  = 40,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  in_clk,
  input  logic                  rst,
  input  logic                  in_latch,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  state,
  output logic                  int_state_1,
  output logic                  int_state_2,
  input  logic                  out_clk,
  output logic                  sout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } fsm_t;

  // bitcnt is 6 bits wide; the frame length is compared in that width
  localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] latch_sync;
  logic                   clk_dly;
  logic                   latch_prev;
  logic                   tick;
  logic                   capture;

  fsm_t                   fsm, fsm_n;
  logic [DATA_WIDTH-1:0]  shreg, shreg_n;
  logic [DATA_WIDTH-1:0]  hold_reg, hold_n;
  logic [5:0]             bitcnt, bitcnt_n;
  logic                   pending, pending_n;
  logic                   sout_n;

  // Bring the out_clk strobe and the latch request into the in_clk domain
  always_ff @(posedge in_clk) begin
    if (rst) begin
      clk_sync   <= '0;
      latch_sync <= '0;
      clk_dly    <= 1'b0;
      latch_prev <= 1'b0;
    end else begin
      clk_sync   <= (clk_sync << 1) | SYNC_STAGES'(out_clk);
      latch_sync <= (latch_sync << 1) | SYNC_STAGES'(in_latch);
      clk_dly    <= clk_sync[SYNC_STAGES-1];
      latch_prev <= latch_sync[SYNC_STAGES-1];
    end
  end

  assign tick    = clk_sync[SYNC_STAGES-1] & ~clk_dly;
  assign capture = latch_sync[SYNC_STAGES-1] & ~latch_prev;

  // Frame sequencing, word consumption and capture; a capture in the consume cycle re-arms pending
  always_comb begin
    fsm_n     = fsm;
    shreg_n   = shreg;
    hold_n    = hold_reg;
    bitcnt_n  = bitcnt;
    pending_n = pending;
    sout_n    = sout;
    if (tick) begin
      case (fsm)
        S_IDLE, S_STOP: begin
          if (pending) begin
            shreg_n   = hold_reg;
            pending_n = 1'b0;
            sout_n    = 1'b0;
            fsm_n     = S_START;
          end else begin
            sout_n = 1'b1;
            fsm_n  = S_IDLE;
          end
        end
        S_START: begin
          sout_n   = shreg[DATA_WIDTH-1];
          bitcnt_n = 6'd1;
          fsm_n    = S_DATA;
        end
        S_DATA: begin
          if (bitcnt < LAST_BIT) begin
            shreg_n  = shreg << 1;
            sout_n   = shreg[DATA_WIDTH-2];
            bitcnt_n = bitcnt + 6'd1;
          end else begin
            sout_n = 1'b1;
            fsm_n  = S_STOP;
          end
        end
        default: fsm_n = S_IDLE;
      endcase
    end
    if (capture) begin
      hold_n    = data;
      pending_n = 1'b1;
    end
  end

  // State register; busy flag is computed from next-state values so it stays a clean flop output
  always_ff @(posedge in_clk) begin
    if (rst) begin
      fsm      <= S_IDLE;
      shreg    <= '0;
      hold_reg <= '0;
      bitcnt   <= '0;
      pending  <= 1'b0;
      sout     <= 1'b1;
      state    <= 1'b0;
    end else begin
      fsm      <= fsm_n;
      shreg    <= shreg_n;
      hold_reg <= hold_n;
      bitcnt   <= bitcnt_n;
      pending  <= pending_n;
      sout     <= sout_n;
      state    <= (fsm_n != S_IDLE) | pending_n;
    end
  end

  assign int_state_1 = fsm[0];
  assign int_state_2 = fsm[1];

endmodule

// File: tb/tb_debug_data_sender.sv
// tb/tb_debug_data_sender.sv - scoreboard bench for debug_data_sender
module tb_debug_data_sender;
  localparam int W = 40;

  logic         in_clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_latch = 1'b0;
  logic         out_clk = 1'b0;
  logic [W-1:0] data = '0;
  logic         state, int_state_1, int_state_2, sout;

  debug_data_sender #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .in_clk(in_clk), .rst(rst), .in_latch(in_latch), .data(data),
    .state(state), .int_state_1(int_state_1), .int_state_2(int_state_2),
    .out_clk(out_clk), .sout(sout)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  typedef struct packed {
    logic       sout;
    logic [1:0] fsm;
    logic       state;
  } exp_t;
  exp_t sb[$];

  // Reference model: a frame is a list of line levels played one per out_clk period
  bit         mq[$];
  int         pos = 0;
  bit         pend = 0;
  bit         m_sout = 1;
  logic [W-1:0] pword = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_tick();
    if (mq.size() == 0 && pend) begin
      mq.push_back(1'b0);
      for (int i = W - 1; i >= 0; i--) mq.push_back(pword[i]);
      mq.push_back(1'b1);
      pend = 0;
      pos = 0;
    end
    if (mq.size() > 0) begin
      m_sout = mq.pop_front();
      pos++;
    end else begin
      m_sout = 1;
      pos = 0;
    end
  endtask

  task automatic m_capture(input logic [W-1:0] d);
    pend = 1;
    pword = d;
  endtask

  task automatic m_reset();
    mq.delete();
    pos = 0;
    pend = 0;
    m_sout = 1;
  endtask

  task automatic push_expected();
    exp_t e;
    e.sout  = m_sout;
    e.fsm   = (pos == 0) ? 2'd0 : (pos == 1) ? 2'd1 : (pos == W + 2) ? 2'd3 : 2'd2;
    e.state = (pos != 0) || pend;
    sb.push_back(e);
  endtask

  // One out_clk period of 24 in_clk cycles; captures sit well clear of the tick
  task automatic run_period(input int ncap, input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input bit keep, input bit rst_mid);
    @(negedge in_clk); out_clk = 1'b1; m_tick();
    repeat (2) @(negedge in_clk);
    if (ncap >= 1) begin data = d0; in_latch = 1'b1; m_capture(d0); end
    repeat (3) @(negedge in_clk);
    if (ncap >= 1 && !keep) in_latch = 1'b0;
    repeat (3) @(negedge in_clk);
    if (ncap >= 2) begin data = d1; in_latch = 1'b1; m_capture(d1); end
    repeat (3) @(negedge in_clk);
    if (ncap >= 2) in_latch = 1'b0;
    repeat (1) @(negedge in_clk);
    out_clk = 1'b0;
    repeat (2) @(negedge in_clk);
    if (rst_mid) rst = 1'b1;
    repeat (1) @(negedge in_clk);
    if (rst_mid) begin
      check("rst_mid_sout", W'(sout), W'(1));
      check("rst_mid_fsm", W'({int_state_2, int_state_1}), W'(0));
      check("rst_mid_state", W'(state), W'(0));
      rst = 1'b0;
      m_reset();
    end
    repeat (3) @(negedge in_clk);
    push_expected();
    repeat (5) @(negedge in_clk);
  endtask

  task automatic idle_periods(input int n);
    for (int i = 0; i < n; i++) run_period(0, '0, '0, 0, 0);
  endtask

  // Monitor: samples the line late in each out_clk period and compares with the scoreboard
  initial begin
    exp_t e;
    wait (started);
    forever begin
      @(negedge out_clk);
      repeat (8) @(negedge in_clk);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got sample with no expected entry at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("sout", W'(sout), W'(e.sout));
        check("fsm", W'({int_state_2, int_state_1}), W'(e.fsm));
        check("state", W'(state), W'(e.state));
      end
    end
  end

  initial begin
    int r;
    rst = 1'b1;
    repeat (2) @(negedge in_clk);
    check("reset_sout", W'(sout), W'(1));
    check("reset_state", W'(state), W'(0));
    check("reset_fsm", W'({int_state_2, int_state_1}), W'(0));
    rst = 1'b0;
    m_reset();
    started = 1;
    idle_periods(2);

    // single frame
    run_period(1, 40'hA999999991, '0, 0, 0);
    idle_periods(44);

    // queued frame, second capture 10 ticks into the first
    run_period(1, 40'hA999999991, '0, 0, 0);
    idle_periods(9);
    run_period(1, 40'hA999999981, '0, 0, 0);
    idle_periods(80);

    // overwrite before the start tick
    run_period(2, 40'hE999999993, 40'h0000000001, 0, 0);
    idle_periods(44);

    // level latch held across several periods
    run_period(1, 40'h5A5A5A5A5A, '0, 1, 0);
    idle_periods(3);
    in_latch = 1'b0;
    idle_periods(42);

    // reset in the middle of DATA
    run_period(1, 40'hFFFF0000FF, '0, 0, 0);
    idle_periods(10);
    run_period(0, '0, '0, 0, 1);
    idle_periods(5);

    // randomised captures and occasional resets
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8)
        run_period(1, {$urandom, $urandom} & {W{1'b1}}, '0, 0, 0);
      else if (r < 11)
        run_period(2, {$urandom, $urandom} & {W{1'b1}}, {$urandom, $urandom} & {W{1'b1}}, 0, 0);
      else if (r < 12)
        run_period(0, '0, '0, 0, 1);
      else
        run_period(0, '0, '0, 0, 0);
    end
    idle_periods(50);
    repeat (30) @(negedge in_clk);
    check("sb_drain", W'(sb.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
